// File: rtl/multi_speed_counter_pkg.sv
// Shared constants for the multi-speed BCD counter: speed-select encoding,
// BCD digit width and the seven-segment glyph table.
package multi_speed_counter_pkg;

  localparam int BCD_W = 4;

  localparam logic [1:0] SPEED_HOLD = 2'b00;
  localparam logic [1:0] SPEED_SLOW = 2'b01;
  localparam logic [1:0] SPEED_MED  = 2'b10;
  localparam logic [1:0] SPEED_FAST = 2'b11;

  // Active-low {g,f,e,d,c,b,a}; entry n is the glyph for digit n.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0010000,
    7'b0000000,
    7'b1111000,
    7'b0000010,
    7'b0010010,
    7'b0011001,
    7'b0110000,
    7'b0100100,
    7'b1111001,
    7'b1000000
  };

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder.
// Codes above 9 cannot occur in the counter; they blank the digit.
module seg7_decode
  import multi_speed_counter_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [6:0]       seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (bcd <= 4'd9) seg = SEG_TABLE[bcd];
  end

endmodule

// File: rtl/multi_speed_counter.sv
// Cascaded BCD up/down counter advanced by a selectable-rate prescaler tick,
// shown on a multiplexed active-low seven-segment display.
module multi_speed_counter
  import multi_speed_counter_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int DIV_BITS  = 22,
  parameter int SCAN_BITS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        sw,
  input  logic              dir,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int PRE_W  = DIV_BITS + 2;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SCAN_W = SCAN_BITS + IDX_W;

  logic [1:0]                   sw_meta, sw_sync, sw_last;
  logic                         dir_meta, dir_sync;
  logic [PRE_W-1:0]             pre, pre_last;
  logic                         sw_changed, tick;
  logic [SCAN_W-1:0]            scan;
  logic [IDX_W-1:0]             idx;
  logic [DIGITS-1:0][BCD_W-1:0] digits, digits_next;
  logic [BCD_W-1:0]             digit_sel;
  logic [6:0]                   seg_dec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      sw_last  <= '0;
      dir_meta <= 1'b0;
      dir_sync <= 1'b0;
    end else begin
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
      sw_last  <= sw_sync;
      dir_meta <= dir;
      dir_sync <= dir_meta;
    end
  end

  always_comb begin
    pre_last = '1;
    case (sw_sync)
      SPEED_FAST: pre_last = PRE_W'({DIV_BITS{1'b1}});
      SPEED_MED:  pre_last = PRE_W'({(DIV_BITS + 1){1'b1}});
      SPEED_SLOW: pre_last = '1;
      default:    pre_last = '1;
    endcase
  end

  // A speed change restarts the period so the first tick at the new rate is a full one.
  assign sw_changed = (sw_sync != sw_last);
  assign tick       = !sw_changed && (sw_sync != SPEED_HOLD) && (pre == pre_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre <= '0;
    end else if (sw_changed || tick) begin
      pre <= '0;
    end else if (sw_sync != SPEED_HOLD) begin
      pre <= pre + PRE_W'(1);
    end
  end

  // Ripple carry/borrow through the digits within a single cycle.
  always_comb begin
    logic carry;
    carry       = tick;
    digits_next = digits;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (!dir_sync) begin
          if (digits[i] == 4'd9) begin
            digits_next[i] = '0;
          end else begin
            digits_next[i] = digits[i] + 4'd1;
            carry          = 1'b0;
          end
        end else begin
          if (digits[i] == 4'd0) begin
            digits_next[i] = 4'd9;
          end else begin
            digits_next[i] = digits[i] - 4'd1;
            carry          = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) digits <= '0;
    else      digits <= digits_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) scan <= '0;
    else      scan <= scan + SCAN_W'(1);
  end

  assign idx       = IDX_W'(32'(scan[SCAN_W-1 -: IDX_W]) % DIGITS);
  assign digit_sel = digits[idx];

  seg7_decode u_seg7_decode (
    .bcd (digit_sel),
    .seg (seg_dec)
  );

  // an and seg are registered together so the glyph never straddles a digit change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= ~DIGITS'(1);
      seg <= SEG_TABLE[0];
    end else begin
      an  <= ~(DIGITS'(1) << idx);
      seg <= seg_dec;
    end
  end

endmodule

// File: tb/tb_multi_speed_counter.sv
// Self-checking bench for multi_speed_counter with DIGITS=2, DIV_BITS=2, SCAN_BITS=1.
module tb_multi_speed_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] sw  = 2'b11;
  logic       dir = 1'b0;
  logic [6:0] seg;
  logic [1:0] an;

  multi_speed_counter #(
    .DIGITS    (2),
    .DIV_BITS  (2),
    .SCAN_BITS (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw),
    .dir (dir),
    .seg (seg),
    .an  (an)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] PAT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef struct {
    logic [7:0] cnt;
    int         gap;
  } exp_t;

  typedef struct {
    string      name;
    logic [1:0] sw;
    logic       dir;
    int         ticks;
    int         first_gap;
    int         gap;
  } vec_t;

  exp_t       exp_q[$];
  vec_t       tbl [8];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_chg = 0;
  int         first_after_rst = -1;
  string      cur_name = "reset";
  logic [7:0] model = 8'h00;
  logic [7:0] prev_count = 8'h00;
  logic [7:0] count_now;

  assign count_now = dut.digits;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] bcd_step(input logic [7:0] c, input logic d);
    int v;
    v = int'(c[7:4]) * 10 + int'(c[3:0]);
    v = d ? (v + 99) % 100 : (v + 1) % 100;
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Scoreboard: each count change pops the next expected value and tick spacing.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_count      = 8'h00;
      last_chg        = cyc;
      first_after_rst = -1;
    end else if (count_now !== prev_count) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s unexpected_change: got %0h, required %0h", cur_name, count_now, prev_count);
      end else begin
        e = exp_q.pop_front();
        check({cur_name, "_count"}, 32'(count_now), 32'(e.cnt));
        if (e.gap > 0) check({cur_name, "_gap"}, cyc - last_chg, e.gap);
      end
      if (first_after_rst < 0) first_after_rst = cyc;
      prev_count = count_now;
      last_chg   = cyc;
    end
  end

  // Displayed glyph must match the digit selected by an, one cycle behind the count.
  logic [7:0] disp_cnt = 8'h00;
  logic       disp_rst = 1'b0;
  logic [6:0] disp_exp;
  always @(negedge clk) begin
    if (rst && disp_rst) begin
      disp_exp = 7'h7f;
      if (an == 2'b10) begin
        if (disp_cnt[3:0] <= 4'd9) disp_exp = PAT[disp_cnt[3:0]];
      end else if (an == 2'b01) begin
        if (disp_cnt[7:4] <= 4'd9) disp_exp = PAT[disp_cnt[7:4]];
      end else begin
        checks++;
        errors++;
        $display("FAIL disp_an: got %b, required one active-low bit", an);
      end
      check("disp_seg", 32'(seg), 32'(disp_exp));
    end
    disp_rst = rst;
    disp_cnt = count_now;
  end

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s timeout: %0d changes pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_ticks(input string name, input logic [1:0] s, input logic d,
                           input int n, input int g0, input int g);
    exp_t e;
    cur_name = name;
    sw       = s;
    dir      = d;
    for (int k = 0; k < n; k++) begin
      model = bcd_step(model, d);
      e.cnt = model;
      e.gap = (k == 0) ? g0 : g;
      exp_q.push_back(e);
    end
    wait_drain(name, n * 20 + 40);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int         rel, c0, toggles, n;
    logic [1:0] a_prev, a_first, exp_an;
    logic [6:0] exp_seg;

    tbl[0] = '{"up_fast_20",   2'b11, 1'b0, 20, -1,  4};
    tbl[1] = '{"up_to_99",     2'b11, 1'b0, 79,  4,  4};
    tbl[2] = '{"wrap_99_00",   2'b11, 1'b0,  1,  4,  4};
    tbl[3] = '{"wrap_00_99",   2'b11, 1'b1,  1,  4,  4};
    tbl[4] = '{"down_to_10",   2'b11, 1'b1, 89,  4,  4};
    tbl[5] = '{"borrow_10_09", 2'b11, 1'b1,  1,  4,  4};
    tbl[6] = '{"medium",       2'b10, 1'b1,  3, -1,  8};
    tbl[7] = '{"slow",         2'b01, 1'b0,  2, -1, 16};

    repeat (3) @(negedge clk);
    #1;
    check("reset_count", 32'(count_now), 32'h00);
    check("reset_an", 32'(an), 32'b10);
    check("reset_seg", 32'(seg), 32'b1000000);

    rst = 1'b1;
    rel = cyc;
    for (int r = 0; r < 8; r++) begin
      run_ticks(tbl[r].name, tbl[r].sw, tbl[r].dir, tbl[r].ticks, tbl[r].first_gap, tbl[r].gap);
      if (r == 0) check("first_tick_after_reset_ge6", 32'((first_after_rst - rel) >= 6), 32'd1);
    end

    cur_name = "hold";
    sw       = 2'b00;
    a_prev   = an;
    toggles  = 0;
    repeat (100) begin
      @(negedge clk);
      #1;
      if (an !== a_prev) toggles++;
      a_prev = an;
    end
    check("hold_count", 32'(count_now), 32'(model));
    check("hold_scan_active", 32'(toggles >= 45), 32'd1);

    run_ticks("hold_exit", 2'b11, 1'b0, 1, -1, 4);

    // Change speed two cycles into a fast period: 2 sync + 16 period + 1 update.
    cur_name = "sw_mid_period";
    sw       = 2'b01;
    c0       = cyc;
    model    = bcd_step(model, 1'b0);
    exp_q.push_back('{model, -1});
    wait_drain("sw_mid_period", 60);
    check("sw_change_latency", last_chg - c0, 19);

    run_ticks("to_42", 2'b11, 1'b0, 32, -1, 4);
    check("count_42", 32'(count_now), 32'h42);

    cur_name = "scan";
    sw       = 2'b00;
    repeat (3) @(negedge clk);
    #1;
    a_prev = an;
    n      = 0;
    while (an === a_prev && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("scan_sync", 32'(an !== a_prev), 32'd1);
    a_first = an;
    check("scan_onehot", 32'((a_first == 2'b10) || (a_first == 2'b01)), 32'd1);
    for (int k = 0; k < 8; k++) begin
      exp_an  = (((k / 2) % 2) == 0) ? a_first : ~a_first;
      exp_seg = (exp_an == 2'b10) ? PAT[2] : PAT[4];
      check("scan_an", 32'(an), 32'(exp_an));
      check("scan_seg", 32'(seg), 32'(exp_seg));
      @(negedge clk);
      #1;
    end

    run_ticks("to_37", 2'b11, 1'b1, 5, -1, 4);
    check("count_37", 32'(count_now), 32'h37);

    @(negedge clk);
    #1;
    cur_name = "mid_reset";
    rst      = 1'b0;
    #1;
    check("mid_reset_count", 32'(count_now), 32'h00);
    check("mid_reset_an", 32'(an), 32'b10);
    check("mid_reset_seg", 32'(seg), 32'b1000000);
    model = 8'h00;
    @(negedge clk);
    #1;
    rst = 1'b1;
    rel = cyc;
    run_ticks("after_reset", 2'b11, 1'b1, 1, -1, 4);
    check("first_tick_after_mid_reset_ge6", 32'((first_after_rst - rel) >= 6), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
